// File: rtl/pipeline_control_unit_if.sv
// Hazard-controller bundle: stage icodes/status flow in from the datapath,
// stall/bubble/set_cc controls flow back out to the pipeline registers.
interface pipeline_control_unit_if;
    logic [3:0] D_icode;
    logic [3:0] E_icode;
    logic [3:0] M_icode;
    logic [3:0] W_icode;
    logic [3:0] E_dstm;
    logic [3:0] d_srca;
    logic [3:0] d_srcb;
    logic       e_cnd;
    logic [1:0] m_status;
    logic [1:0] W_status;
    logic       F_stall;
    logic       D_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       W_stall;
    logic       set_cc;

    modport master (
        output D_icode, E_icode, M_icode, W_icode, E_dstm, d_srca, d_srcb,
               e_cnd, m_status, W_status,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
    );

    modport slave (
        input  D_icode, E_icode, M_icode, W_icode, E_dstm, d_srca, d_srcb,
               e_cnd, m_status, W_status,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// Y86-64 5-stage hazard/exception controller: load/use, ret and mispredict
// handling, exception freeze, FLUSH/RUN/HALT run state and saturating counters.
module pipeline_control_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    pipeline_control_unit_if.slave pipe,
    output logic                   halted,
    output logic [1:0]             proc_status,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       retire_cnt,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       bubble_cnt
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_HALT} state_e;

    state_e           state_q;
    logic             halted_q;
    logic [1:0]       status_q;
    logic [CNT_W-1:0] cycle_q, retire_q, stall_q, bubble_q;
    logic [CNT_W-1:0] cycle_d, retire_d, stall_d, bubble_d;
    logic             lu, ret, mp, mx, wx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_ONE : v;
    endfunction

    always_comb begin
        lu  = ((pipe.E_icode == I_MRMOVQ) || (pipe.E_icode == I_POPQ)) &&
              (pipe.E_dstm != RNONE) &&
              ((pipe.E_dstm == pipe.d_srca) || (pipe.E_dstm == pipe.d_srcb));
        ret = (pipe.D_icode == I_RET) || (pipe.E_icode == I_RET) || (pipe.M_icode == I_RET);
        mp  = (pipe.E_icode == I_JXX) && !pipe.e_cnd;
        mx  = (pipe.m_status != 2'd0);
        wx  = (pipe.W_status != 2'd0);
    end

    // NOTE: every control is defaulted before the branches, so no path can infer a latch.
    always_comb begin
        pipe.F_stall  = 1'b0;
        pipe.D_stall  = 1'b0;
        pipe.D_bubble = 1'b0;
        pipe.E_bubble = 1'b0;
        pipe.M_bubble = 1'b0;
        pipe.W_stall  = 1'b0;
        pipe.set_cc   = 1'b0;
        if (reset || (state_q == ST_FLUSH)) begin
            pipe.F_stall  = 1'b1;
            pipe.D_bubble = 1'b1;
            pipe.E_bubble = 1'b1;
            pipe.M_bubble = 1'b1;
        end else if (state_q == ST_HALT) begin
            pipe.F_stall  = 1'b1;
            pipe.D_stall  = 1'b1;
            pipe.W_stall  = 1'b1;
            pipe.M_bubble = 1'b1;
        end else begin
            // Load/use stall takes priority over the ret bubble in decode.
            pipe.F_stall  = lu | ret;
            pipe.D_stall  = lu;
            pipe.D_bubble = mp | (ret & ~lu);
            pipe.E_bubble = mp | lu;
            pipe.M_bubble = mx | wx;
            pipe.W_stall  = wx;
            pipe.set_cc   = (pipe.E_icode == I_OPQ) & ~mx & ~wx;
        end
    end

    always_comb begin
        cycle_d  = sat_inc(cycle_q, 1'b1);
        retire_d = sat_inc(retire_q, (pipe.W_icode != I_NOP) && !wx);
        stall_d  = sat_inc(stall_q, pipe.F_stall | pipe.D_stall);
        bubble_d = sat_inc(bubble_q, pipe.D_bubble | pipe.E_bubble | pipe.M_bubble);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_FLUSH;
            halted_q <= 1'b0;
            status_q <= 2'd0;
            cycle_q  <= '0;
            retire_q <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            unique case (state_q)
                ST_FLUSH: state_q <= ST_RUN;
                ST_RUN: begin
                    cycle_q  <= cycle_d;
                    retire_q <= retire_d;
                    stall_q  <= stall_d;
                    bubble_q <= bubble_d;
                    if (wx) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                        status_q <= pipe.W_status;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_FLUSH;
            endcase
        end
    end

    assign halted      = halted_q;
    assign proc_status = status_q;
    assign cycle_cnt   = cycle_q;
    assign retire_cnt  = retire_q;
    assign stall_cnt   = stall_q;
    assign bubble_cnt  = bubble_q;
endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: directed hazard cases plus random
// episodes, checked against a spec-level model; a 4-bit instance covers saturation.
module tb_pipeline_control_unit;
    typedef struct packed {
        logic       rst;
        logic [3:0] d, e, m, w, dstm, sa, sb;
        logic       cnd;
        logic [1:0] ms, ws;
    } stim_t;

    typedef struct packed {
        logic [6:0]  ctrl;   // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
        logic        halted;
        logic [1:0]  st;
        logic [63:0] cyc, ret, stl, bub;
        logic [63:0] scyc, sret, sstl, sbub;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipeline_control_unit_if bus ();
    pipeline_control_unit_if bus_s ();

    logic        halted, s_halted;
    logic [1:0]  proc_status, s_status;
    logic [31:0] cyc, ret, stl, bub;
    logic [3:0]  s_cyc, s_ret, s_stl, s_bub;

    assign bus_s.D_icode  = bus.D_icode;
    assign bus_s.E_icode  = bus.E_icode;
    assign bus_s.M_icode  = bus.M_icode;
    assign bus_s.W_icode  = bus.W_icode;
    assign bus_s.E_dstm   = bus.E_dstm;
    assign bus_s.d_srca   = bus.d_srca;
    assign bus_s.d_srcb   = bus.d_srcb;
    assign bus_s.e_cnd    = bus.e_cnd;
    assign bus_s.m_status = bus.m_status;
    assign bus_s.W_status = bus.W_status;

    pipeline_control_unit #(.CNT_W(32)) dut (
        .clock(clock), .reset(reset), .pipe(bus), .halted(halted), .proc_status(proc_status),
        .cycle_cnt(cyc), .retire_cnt(ret), .stall_cnt(stl), .bubble_cnt(bub)
    );

    pipeline_control_unit #(.CNT_W(4)) dut_s (
        .clock(clock), .reset(reset), .pipe(bus_s), .halted(s_halted), .proc_status(s_status),
        .cycle_cnt(s_cyc), .retire_cnt(s_ret), .stall_cnt(s_stl), .bubble_cnt(s_bub)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: processor run state as flags, counters as plain saturating integers.
    bit          m_flush, m_halt;
    logic [1:0]  m_stat;
    logic [63:0] m_cnt[4];
    logic [63:0] m_scnt[4];
    localparam logic [63:0] MAX32 = 64'hFFFF_FFFF;
    localparam logic [63:0] MAX4  = 64'hF;

    function automatic logic [63:0] sat(input logic [63:0] v, input bit en, input logic [63:0] mx);
        return (en && v < mx) ? v + 64'd1 : v;
    endfunction

    task automatic model_reset();
        m_flush = 1'b1;
        m_halt  = 1'b0;
        m_stat  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = '0;
            m_scnt[i] = '0;
        end
    endtask

    task automatic model_step(input stim_t s, output exp_t e);
        bit lu, rt, mp, mx, wx;
        bit fs, ds, db, eb, mb, wsl, cc;
        bit inc[4];
        lu = (s.e == 4'h5 || s.e == 4'hB) && s.dstm != 4'hF && (s.dstm == s.sa || s.dstm == s.sb);
        rt = (s.d == 4'h9) || (s.e == 4'h9) || (s.m == 4'h9);
        mp = (s.e == 4'h7) && !s.cnd;
        mx = (s.ms != 2'd0);
        wx = (s.ws != 2'd0);
        {fs, ds, db, eb, mb, wsl, cc} = 7'b0;
        if (s.rst || m_flush) begin
            fs = 1; db = 1; eb = 1; mb = 1;
        end else if (m_halt) begin
            fs = 1; ds = 1; wsl = 1; mb = 1;
        end else begin
            fs = lu | rt;  ds = lu;       db = mp | (rt & !lu);
            eb = mp | lu;  mb = mx | wx;  wsl = wx;
            cc = (s.e == 4'h6) && !mx && !wx;
        end
        e = '0;
        e.ctrl   = {fs, ds, db, eb, mb, wsl, cc};
        e.halted = m_halt;
        e.st     = m_stat;
        {e.cyc, e.ret, e.stl, e.bub}     = {m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]};
        {e.scyc, e.sret, e.sstl, e.sbub} = {m_scnt[0], m_scnt[1], m_scnt[2], m_scnt[3]};
        if (s.rst) begin
            model_reset();
        end else if (m_flush) begin
            m_flush = 1'b0;
        end else if (!m_halt) begin
            inc = '{1'b1, (s.w != 4'h1) && !wx, fs | ds, db | eb | mb};
            for (int i = 0; i < 4; i++) begin
                m_cnt[i]  = sat(m_cnt[i], inc[i], MAX32);
                m_scnt[i] = sat(m_scnt[i], inc[i], MAX4);
            end
            if (wx) begin
                m_halt = 1'b1;
                m_stat = s.ws;
            end
        end
    endtask

    task automatic apply(input stim_t s);
        reset        = s.rst;
        bus.D_icode  = s.d;
        bus.E_icode  = s.e;
        bus.M_icode  = s.m;
        bus.W_icode  = s.w;
        bus.E_dstm   = s.dstm;
        bus.d_srca   = s.sa;
        bus.d_srcb   = s.sb;
        bus.e_cnd    = s.cnd;
        bus.m_status = s.ms;
        bus.W_status = s.ws;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        apply(s);
        model_step(s, e);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    function automatic stim_t nop();
        stim_t s;
        s      = '0;
        s.d    = 4'h1; s.e = 4'h1; s.m = 4'h1; s.w = 4'h1;
        s.dstm = 4'hF; s.sa = 4'hF; s.sb = 4'hF;
        return s;
    endfunction

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s      = '0;
        s.d    = 4'($urandom_range(0, 11));
        s.e    = 4'($urandom_range(0, 11));
        s.m    = 4'($urandom_range(0, 11));
        s.w    = 4'($urandom_range(0, 11));
        s.dstm = rand_reg();
        s.sa   = rand_reg();
        s.sb   = rand_reg();
        s.cnd  = 1'($urandom_range(0, 1));
        s.ms   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        s.ws   = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        return s;
    endfunction

    // Monitor: compares every pending expectation halfway through its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ctrl", {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                               bus.M_bubble, bus.W_stall, bus.set_cc}, e.ctrl);
                check("halted", halted, e.halted);
                check("proc_status", proc_status, e.st);
                check("cycle_cnt", cyc, e.cyc);
                check("retire_cnt", ret, e.ret);
                check("stall_cnt", stl, e.stl);
                check("bubble_cnt", bub, e.bub);
                check("sat_halted", s_halted, e.halted);
                check("sat_status", s_status, e.st);
                check("sat_cycle_cnt", s_cyc, e.scyc);
                check("sat_retire_cnt", s_ret, e.sret);
                check("sat_stall_cnt", s_stl, e.sstl);
                check("sat_bubble_cnt", s_bub, e.sbub);
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cnt;
        apply('{rst: 1'b1, d: 4'h1, e: 4'h1, m: 4'h1, w: 4'h1, dstm: 4'hF, sa: 4'hF, sb: 4'hF,
                cnd: 1'b0, ms: 2'd0, ws: 2'd0});
        @(posedge clock);
        #1;
        model_reset();

        // Reset cycle, FLUSH cycle, then idle RUN.
        s = nop(); s.rst = 1'b1; drive(s);
        repeat (4) drive(nop());

        // Load/use on srcA (MRMOVQ) and srcB (POPQ), then no-destination case.
        s = nop(); s.e = 4'h5; s.dstm = 4'h3; s.sa = 4'h3; drive(s);
        s.dstm = 4'hF; drive(s);
        s = nop(); s.e = 4'hB; s.dstm = 4'h2; s.sb = 4'h2; drive(s);

        // ret walking through D, E, M.
        s = nop(); s.d = 4'h9; drive(s);
        s = nop(); s.e = 4'h9; drive(s);
        s = nop(); s.m = 4'h9; drive(s);

        // ret together with load/use: stall must win over the decode bubble.
        s = nop(); s.d = 4'h9; s.e = 4'h5; s.dstm = 4'h1; s.sb = 4'h1; drive(s);

        // Mispredicted and correctly predicted jump.
        s = nop(); s.e = 4'h7; s.cnd = 1'b0; drive(s);
        s.cnd = 1'b1; drive(s);

        // OPq with memory exception, then writeback exception freezes the pipe.
        s = nop(); s.e = 4'h6; drive(s);
        s.ms = 2'd2; drive(s);
        s = nop(); s.ws = 2'd2; drive(s);
        repeat (3) drive(nop());
        s = nop(); s.ws = 2'd3; drive(s);

        // Reset out of HALT, then enough RUN cycles to saturate the 4-bit counters.
        s = nop(); s.rst = 1'b1; drive(s);
        repeat (22) drive(nop());

        // Random episodes, each opened by a reset from whatever state the last one left.
        for (int ep = 0; ep < 10; ep++) begin
            s = rand_stim(); s.rst = 1'b1; drive(s);
            repeat (40) drive(rand_stim());
        end

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 8) begin
            @(negedge clock);
            wait_cnt++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
